// File: rtl/ifu_if.sv
// Fetch-side bus bundle: instruction-memory request/response channel,
// decode-facing instruction channel and the execute redirect.
// The master modport is the fetch unit; the slave modport is its environment
// (memory, decode and execute taken together).
interface ifu_if #(
  parameter int XLEN = 64
);

  // Control-flow redirect from execute
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  // Instruction memory request channel
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;

  // Instruction memory response channel (always accepted)
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            imem_resp_err;

  // Decode-facing instruction channel
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic [1:0]      inst_err;

  modport master (
    input  redirect,
    input  redirect_pc,
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  imem_resp_err,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc,
    output inst_err
  );

  modport slave (
    output redirect,
    output redirect_pc,
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_resp_valid,
    output imem_resp_data,
    output imem_resp_err,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc,
    input  inst_err
  );

endinterface

// File: rtl/ifu.sv
// Instruction fetch unit.
// Owns the architectural PC and keeps at most one instruction read
// outstanding. Each fetched word is parked in a registered output slot
// until decode takes it. A redirect from execute always wins: it retargets
// the PC, drops any held word and marks an in-flight read for discard.
// A misaligned redirect target never reaches memory; it is reported to
// decode as a NOP carrying the misaligned-fetch error code.
module ifu #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000)
) (
  input  logic   clk,
  input  logic   rst_n,
  ifu_if.master  bus
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,   // presenting a read request at pc
    WAIT = 2'd1,   // one read outstanding
    HOLD = 2'd2    // output slot full, waiting for decode
  } state_t;

  localparam logic [31:0]     NOP_INST       = 32'h0000_0013;
  localparam logic [1:0]      ERR_NONE       = 2'd0;
  localparam logic [1:0]      ERR_MISALIGNED = 2'd1;
  localparam logic [1:0]      ERR_ACCESS     = 2'd2;
  localparam logic [XLEN-1:0] PC_STEP        = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [XLEN-1:0] PC_ZERO        = {XLEN{1'b0}};

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  // Map a memory access-fault flag onto the decode error code.
  function automatic logic [1:0] resp_err_code(input logic fault);
    return fault ? ERR_ACCESS : ERR_NONE;
  endfunction

  state_t          state_r;
  logic [XLEN-1:0] pc_r;
  logic            kill_r;      // outstanding read is stale, discard it
  logic            mis_r;       // stale read hides a misaligned redirect
  logic            inst_valid_r;
  logic [31:0]     inst_r;
  logic [XLEN-1:0] inst_pc_r;
  logic [1:0]      inst_err_r;

  logic in_flight;      // a read will still be outstanding after this edge
  logic redirect_mis;   // current redirect target is misaligned

  // Decide whether a redirect this cycle leaves a read in flight behind it.
  always_comb begin
    in_flight    = 1'b0;
    redirect_mis = is_misaligned(bus.redirect_pc);
    if (state_r == REQ) begin
      in_flight = bus.imem_req_ready;
    end else if (state_r == WAIT) begin
      in_flight = !bus.imem_resp_valid;
    end else begin
      in_flight = 1'b0;
    end
  end

  // Fetch FSM: PC, kill tracking and the registered decode-facing slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= REQ;
      pc_r         <= RESET_PC;
      kill_r       <= 1'b0;
      mis_r        <= 1'b0;
      inst_valid_r <= 1'b0;
      inst_r       <= 32'h0000_0000;
      inst_pc_r    <= PC_ZERO;
      inst_err_r   <= ERR_NONE;
    end else if (bus.redirect) begin
      // Redirect beats everything, including a same-cycle decode accept.
      pc_r         <= bus.redirect_pc;
      inst_valid_r <= 1'b0;
      if (in_flight) begin
        // Let the stale read drain first; remember if the target was bad.
        state_r <= WAIT;
        kill_r  <= 1'b1;
        mis_r   <= redirect_mis;
      end else if (redirect_mis) begin
        // Nothing to drain: report the misaligned target immediately.
        state_r      <= HOLD;
        kill_r       <= 1'b0;
        mis_r        <= 1'b0;
        inst_valid_r <= 1'b1;
        inst_r       <= NOP_INST;
        inst_pc_r    <= bus.redirect_pc;
        inst_err_r   <= ERR_MISALIGNED;
      end else begin
        state_r <= REQ;
        kill_r  <= 1'b0;
        mis_r   <= 1'b0;
      end
    end else begin
      case (state_r)
        REQ: begin
          if (bus.imem_req_ready) begin
            state_r <= WAIT;
          end else begin
            state_r <= REQ;
          end
        end
        WAIT: begin
          if (bus.imem_resp_valid) begin
            if (kill_r) begin
              // Stale response: throw it away.
              kill_r <= 1'b0;
              mis_r  <= 1'b0;
              if (mis_r) begin
                state_r      <= HOLD;
                inst_valid_r <= 1'b1;
                inst_r       <= NOP_INST;
                inst_pc_r    <= pc_r;
                inst_err_r   <= ERR_MISALIGNED;
              end else begin
                state_r <= REQ;
              end
            end else begin
              state_r      <= HOLD;
              inst_valid_r <= 1'b1;
              inst_r       <= bus.imem_resp_data;
              inst_pc_r    <= pc_r;
              inst_err_r   <= resp_err_code(bus.imem_resp_err);
            end
          end else begin
            state_r <= WAIT;
          end
        end
        HOLD: begin
          if (inst_valid_r && bus.inst_ready) begin
            inst_valid_r <= 1'b0;
            pc_r         <= pc_r + PC_STEP;
            state_r      <= REQ;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r      <= REQ;
          kill_r       <= 1'b0;
          mis_r        <= 1'b0;
          inst_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Request side is a direct decode of state and pc; decode side is registered.
  always_comb begin
    bus.imem_req_valid = (state_r == REQ);
    bus.imem_req_addr  = pc_r;
    bus.inst_valid     = inst_valid_r;
    bus.inst           = inst_r;
    bus.inst_pc        = inst_pc_r;
    bus.inst_err       = inst_err_r;
  end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for the fetch unit. Stimulus pushes expected requests and
// expected delivered instructions into queues; independent monitors pop and
// compare whenever the DUT fires a request or delivers a word.
module tb_ifu;

  localparam int          XLEN   = 64;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ifu_if #(.XLEN(XLEN)) bus ();

  ifu #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct packed {
    logic [31:0] word;
    logic [63:0] pc;
    logic [1:0]  err;
  } inst_exp_t;

  inst_exp_t   inst_q[$];
  logic [63:0] req_q[$];
  int          vectors     = 0;
  int          miscompares = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_inst(input logic [31:0] w, input logic [63:0] pc, input logic [1:0] e);
    inst_exp_t x;
    x.word = w;
    x.pc   = pc;
    x.err  = e;
    inst_q.push_back(x);
  endtask

  // Memory model: fixed latency, word derived from the address.
  int          lat       = 1;
  int          cnt       = 0;
  logic [63:0] pend_addr = 64'h0;
  logic [63:0] err_addr  = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    if (a == RST_PC) return 32'h0000_0093;
    else return {a[15:0], 16'h0013};
  endfunction

  // Responder: drives one response cycle 'lat' cycles after each accepted request.
  always @(negedge clk) begin
    #1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.imem_resp_err   = 1'b0;
    if (rst_n !== 1'b1) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.imem_resp_valid = 1'b1;
          bus.imem_resp_data  = word_at(pend_addr);
          bus.imem_resp_err   = (pend_addr == err_addr);
        end
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        cnt       = lat;
        pend_addr = bus.imem_req_addr;
      end
    end
  end

  // Monitors: compare each request fire and each delivered word against the queues.
  always @(negedge clk) begin
    inst_exp_t e;
    #2;
    if (rst_n === 1'b1) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (req_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL req_unexpected: got request at %h, expected none", bus.imem_req_addr);
        end else begin
          check64("req_addr", bus.imem_req_addr, req_q.pop_front());
        end
      end
      if (bus.inst_valid && bus.inst_ready && !bus.redirect) begin
        if (inst_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL inst_unexpected: got %h at pc %h, expected none", bus.inst, bus.inst_pc);
        end else begin
          e = inst_q.pop_front();
          check64("inst_word", 64'(bus.inst), 64'(e.word));
          check64("inst_pc", bus.inst_pc, e.pc);
          check64("inst_err", 64'(bus.inst_err), 64'(e.err));
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus, one block per cycle after reset release.
  initial begin
    rst_n              = 1'b0;
    bus.redirect       = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    repeat (3) @(negedge clk);

    // Reset release, 1-cycle memory, error on 0x80000008
    rst_n    = 1'b1;
    err_addr = 64'h0000_0000_8000_0008;
    req_q.push_back(RST_PC);
    push_inst(32'h0000_0093, RST_PC, 2'd0);
    req_q.push_back(64'h0000_0000_8000_0004);
    push_inst(32'h0004_0013, 64'h0000_0000_8000_0004, 2'd0);
    req_q.push_back(64'h0000_0000_8000_0008);
    push_inst(32'h0008_0013, 64'h0000_0000_8000_0008, 2'd2);
    req_q.push_back(64'h0000_0000_8000_000C);
    #2;
    check64("c1_req_valid", 64'(bus.imem_req_valid), 64'd1);
    check64("c1_req_addr", bus.imem_req_addr, RST_PC);
    check64("c1_inst_valid", 64'(bus.inst_valid), 64'd0);
    @(negedge clk); #2;
    check64("c2_inst_valid", 64'(bus.inst_valid), 64'd0);
    check64("c2_req_valid", 64'(bus.imem_req_valid), 64'd0);
    @(negedge clk); #2;
    check64("c3_inst_valid", 64'(bus.inst_valid), 64'd1);
    check64("c3_inst_pc", bus.inst_pc, RST_PC);
    @(negedge clk); #2;
    check64("c4_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_0004);

    // Decode stall for 5 cycles
    @(negedge clk);
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      check64("stall_inst_valid", 64'(bus.inst_valid), 64'd1);
      check64("stall_inst_pc", bus.inst_pc, 64'h0000_0000_8000_0004);
      check64("stall_inst", 64'(bus.inst), 64'h0000_0000_0004_0013);
      check64("stall_req_valid", 64'(bus.imem_req_valid), 64'd0);
    end
    @(negedge clk);
    bus.inst_ready = 1'b1;
    @(negedge clk); #2;
    check64("after_stall_addr", bus.imem_req_addr, 64'h0000_0000_8000_0008);

    // Access fault response
    @(negedge clk);
    @(negedge clk); #2;
    check64("fault_valid", 64'(bus.inst_valid), 64'd1);
    check64("fault_err", 64'(bus.inst_err), 64'd2);
    check64("fault_pc", bus.inst_pc, 64'h0000_0000_8000_0008);

    // Reset in the middle of WAIT
    @(negedge clk);
    lat = 3;
    #2;
    check64("pre_rst_addr", bus.imem_req_addr, 64'h0000_0000_8000_000C);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_q.push_back(RST_PC);
    #2;
    check64("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    check64("rst_inst", 64'(bus.inst), 64'd0);
    check64("rst_inst_pc", bus.inst_pc, 64'd0);
    check64("rst_inst_err", 64'(bus.inst_err), 64'd0);
    check64("rst_req_valid", 64'(bus.imem_req_valid), 64'd1);
    check64("rst_req_addr", bus.imem_req_addr, RST_PC);

    // Redirect during WAIT, stale response two cycles later
    @(negedge clk);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'h0000_0000_8000_0100;
    #2;
    check64("rw_inst_valid0", 64'(bus.inst_valid), 64'd0);
    @(negedge clk);
    bus.redirect = 1'b0;
    #2;
    check64("rw_inst_valid1", 64'(bus.inst_valid), 64'd0);
    check64("rw_req_valid1", 64'(bus.imem_req_valid), 64'd0);
    @(negedge clk); #2;
    check64("rw_inst_valid2", 64'(bus.inst_valid), 64'd0);
    check64("rw_req_valid2", 64'(bus.imem_req_valid), 64'd0);
    @(negedge clk);
    lat = 1;
    req_q.push_back(64'h0000_0000_8000_0100);
    #2;
    check64("rw_inst_valid3", 64'(bus.inst_valid), 64'd0);
    check64("rw_req_valid3", 64'(bus.imem_req_valid), 64'd1);
    check64("rw_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_0100);

    // Redirect coincident with HOLD and inst_ready
    @(negedge clk);
    @(negedge clk);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'h0000_0000_8000_0200;
    req_q.push_back(64'h0000_0000_8000_0200);
    push_inst(32'h0200_0013, 64'h0000_0000_8000_0200, 2'd0);
    #2;
    check64("rh_inst_valid", 64'(bus.inst_valid), 64'd1);
    check64("rh_inst_pc", bus.inst_pc, 64'h0000_0000_8000_0100);
    @(negedge clk);
    bus.redirect = 1'b0;
    #2;
    check64("rh_dropped", 64'(bus.inst_valid), 64'd0);
    check64("rh_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_0200);
    @(negedge clk);
    @(negedge clk);

    // Misaligned redirect with nothing in flight
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    bus.redirect       = 1'b1;
    bus.redirect_pc    = 64'h0000_0000_8000_0102;
    push_inst(32'h0000_0013, 64'h0000_0000_8000_0102, 2'd1);
    #2;
    check64("mis_prev_addr", bus.imem_req_addr, 64'h0000_0000_8000_0204);
    @(negedge clk);
    bus.redirect = 1'b0;
    #2;
    check64("mis_valid", 64'(bus.inst_valid), 64'd1);
    check64("mis_inst", 64'(bus.inst), 64'h0000_0000_0000_0013);
    check64("mis_pc", bus.inst_pc, 64'h0000_0000_8000_0102);
    check64("mis_err", 64'(bus.inst_err), 64'd1);
    check64("mis_no_req", 64'(bus.imem_req_valid), 64'd0);

    // Misaligned redirect with a request accepted the same cycle
    @(negedge clk);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'h0000_0000_8000_0300;
    #2;
    check64("mis2_addr_pre", bus.imem_req_addr, 64'h0000_0000_8000_0106);
    @(negedge clk);
    bus.imem_req_ready = 1'b1;
    bus.redirect_pc    = 64'h0000_0000_8000_0306;
    req_q.push_back(64'h0000_0000_8000_0300);
    push_inst(32'h0000_0013, 64'h0000_0000_8000_0306, 2'd1);
    #2;
    check64("mis2_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_0300);
    @(negedge clk);
    bus.redirect = 1'b0;
    #2;
    check64("mis2_wait_valid", 64'(bus.inst_valid), 64'd0);
    check64("mis2_wait_req", 64'(bus.imem_req_valid), 64'd0);
    @(negedge clk); #2;
    check64("mis2_valid", 64'(bus.inst_valid), 64'd1);
    check64("mis2_err", 64'(bus.inst_err), 64'd1);
    check64("mis2_pc", bus.inst_pc, 64'h0000_0000_8000_0306);

    // PC wrap from the top of the address space
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    bus.redirect       = 1'b1;
    bus.redirect_pc    = TOP_PC;
    req_q.push_back(TOP_PC);
    push_inst(32'hFFFC_0013, TOP_PC, 2'd0);
    req_q.push_back(64'h0);
    push_inst(32'h0000_0013, 64'h0, 2'd0);
    #2;
    check64("wrap_prev_addr", bus.imem_req_addr, 64'h0000_0000_8000_030A);
    @(negedge clk);
    bus.redirect       = 1'b0;
    bus.imem_req_ready = 1'b1;
    #2;
    check64("wrap_top_addr", bus.imem_req_addr, TOP_PC);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #2;
    check64("wrap_zero_addr", bus.imem_req_addr, 64'h0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    #2;
    check64("wrap_next_addr", bus.imem_req_addr, 64'h4);

    repeat (3) @(negedge clk);
    #3;
    check64("req_queue_drained", 64'(req_q.size()), 64'd0);
    check64("inst_queue_drained", 64'(inst_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
